// File: rtl/hazard_pkg.sv
// hazard_pkg: opcodes, shadow-stage record and FSM states for the hazard controller.
package hazard_pkg;
    localparam logic [3:0] OP_HALT = 4'b0000;
    localparam logic [3:0] OP_BR   = 4'b0010;
    localparam logic [3:0] OP_JMP  = 4'b0100;
    localparam logic [3:0] OP_ST   = 4'b0110;
    localparam logic [3:0] OP_LD   = 4'b1000;

    typedef struct packed {
        logic       valid;
        logic       wr;
        logic [2:0] dst;
        logic       load;
        logic       ctl;
    } stage_t;

    typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

    function automatic logic hits(input stage_t s, input logic [2:0] r, input logic used);
        return used & s.valid & s.wr & (s.dst == r);
    endfunction
endpackage

// File: rtl/hazard_shadow.sv
// hazard_shadow: 3-deep EX/MEM/WB record of issued instructions, cleared by rst.
module hazard_shadow
    import hazard_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  stage_t ex_i,
    output stage_t ex_o,
    output stage_t mem_o,
    output stage_t wb_o
);
    stage_t ex_q, mem_q, wb_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            wb_q  <= mem_q;
            mem_q <= ex_q;
            ex_q  <= ex_i;
        end
    end

    assign ex_o  = ex_q;
    assign mem_o = mem_q;
    assign wb_o  = wb_q;
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/bubble/flush and halt-drain control for the 5-stage core.
// Define FORWARD_EN when the EX/MEM/WB bypass exists (only load-use then stalls).
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [15:0]      id_inst,
    input  logic             ex_taken,
    output logic             stall_if,
    output logic             bubble_ex,
    output logic             flush_id,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cycles
);
    logic [3:0]       op;
    logic [2:0]       dst, src_a, src_b;
    logic             uses_a, uses_b, halt_op, hazard, flush, issue, hold;
    stage_t           id_st, ex_d, ex_q, mem_q, wb_q;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             unused;

    assign op      = id_inst[15:12];
    assign dst     = id_inst[11:9];
    assign src_a   = id_inst[14] ? id_inst[11:9] : id_inst[5:3];
    assign src_b   = id_inst[8:6];
    assign uses_a  = (op != OP_HALT) && (op != OP_JMP);
    assign uses_b  = ~id_inst[13] & (op != OP_HALT);
    assign halt_op = op == OP_HALT;
    assign id_st   = '{valid: 1'b1, wr: id_inst[15], dst: dst, load: op == OP_LD,
                       ctl: (op == OP_BR) || (op == OP_JMP)};

`ifdef FORWARD_EN
    assign hazard = id_valid & ex_q.load & (hits(ex_q, src_a, uses_a) | hits(ex_q, src_b, uses_b));
    assign unused = ^{id_inst[2:0], mem_q[5:0], wb_q};
`else
    assign hazard = id_valid & (hits(ex_q, src_a, uses_a) | hits(ex_q, src_b, uses_b) |
                                hits(mem_q, src_a, uses_a) | hits(mem_q, src_b, uses_b) |
                                hits(wb_q, src_a, uses_a) | hits(wb_q, src_b, uses_b));
    assign unused = ^{id_inst[2:0], mem_q.load, mem_q.ctl, wb_q.load, wb_q.ctl};
`endif

    assign flush = ex_taken & ex_q.valid & ex_q.ctl;
    assign issue = id_valid & (state_q == RUN) & ~hazard & ~flush & ~halt_op;
    assign ex_d  = issue ? id_st : '0;
    // A halt sitting in decode holds fetch from the cycle it is seen.
    assign hold  = (state_q != RUN) | (id_valid & halt_op);

    assign flush_id  = ~rst & flush;
    assign bubble_ex = ~rst & (flush | hazard | hold);
    assign stall_if  = ~rst & ~flush & (hazard | hold);
    assign halted       = state_q == HALTED;
    assign stall_cycles = cnt_q;

    hazard_shadow u_shadow (
        .clk   (clk),
        .rst   (rst),
        .ex_i  (ex_d),
        .ex_o  (ex_q),
        .mem_o (mem_q),
        .wb_o  (wb_q)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == RUN && id_valid && halt_op && !flush)
            state_d = DRAIN;
        else if (state_q == DRAIN && !(ex_q.valid | mem_q.valid | wb_q.valid))
            state_d = HALTED;
        cnt_d = (hazard && !flush && state_q == RUN && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule
